// File: rtl/imem_fetch_server_if.sv
// Load/fetch bus of imem_fetch_server: program-load handshake, run control and fetch outputs.
// master = program loader / CPU side, slave = imem_fetch_server.
interface imem_fetch_server_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] i_datain;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        halted;
  logic [5:0]  prog_len;

  modport master (
    output load_valid, load_data, load_last, run, stall, redirect, redirect_pc,
    input  load_ready, i_datain, pc_out, fetch_valid, halted, prog_len
  );

  modport slave (
    input  load_valid, load_data, load_last, run, stall, redirect, redirect_pc,
    output load_ready, i_datain, pc_out, fetch_valid, halted, prog_len
  );
endinterface

// File: rtl/imem_fetch_server.sv
// 32-word instruction memory: loaded word-by-word, then streamed to the CPU one word per cycle.
// Optional macro HALT_ON_END_EN: stop in HALT once pc runs past the loaded program.
module imem_fetch_server (
  input logic clock,
  input logic reset,
  imem_fetch_server_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t           state;
  logic [XLEN-1:0]  mem [DEPTH];
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  iData;
  logic [XLEN-1:0]  pcOut;
  logic [CNT_W-1:0] wrPtr;
  logic [CNT_W-1:0] progLen;
  logic             fetchValid;
  logic             halted;
  logic             loadReady;

  logic             accept;
  logic [IDX_W-1:0] wrIdx;
  logic             endOfProg;

  assign accept = bus.load_valid && loadReady;
  // The first word of a new load always lands at index 0.
  assign wrIdx  = (state == IDLE) ? '0 : wrPtr[IDX_W-1:0];

`ifdef HALT_ON_END_EN
  assign endOfProg = (pc[XLEN-1:2] >= 30'(progLen));
`else
  assign endOfProg = 1'b0;
`endif

  // Program storage; deliberately not reset so a reset never wipes a loaded program.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wrIdx] <= bus.load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      wrPtr      <= '0;
      progLen    <= '0;
      iData      <= '0;
      pcOut      <= '0;
      fetchValid <= 1'b0;
      halted     <= 1'b0;
      loadReady  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wrPtr <= CNT_W'(1);
            // A one-word program completes immediately.
            if (bus.load_last) begin
              progLen <= CNT_W'(1);
            end else begin
              state <= LOAD;
            end
          end else if (bus.run && !bus.load_valid) begin
            state     <= RUN;
            pc        <= '0;
            loadReady <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            wrPtr <= wrPtr + CNT_W'(1);
            if (bus.load_last || (wrPtr == CNT_W'(DEPTH - 1))) begin
              state     <= IDLE;
              progLen   <= wrPtr + CNT_W'(1);
              loadReady <= (wrPtr != CNT_W'(DEPTH - 1));
            end
          end
        end
        RUN: begin
          if (bus.redirect) begin
            pc         <= bus.redirect_pc & ~XLEN'(3);
            iData      <= '0;
            fetchValid <= 1'b0;
          end else if (!bus.stall) begin
            if (endOfProg) begin
              state      <= HALT;
              halted     <= 1'b1;
              iData      <= '0;
              fetchValid <= 1'b0;
            end else begin
              iData      <= mem[pc[IDX_W+1:2]];
              pcOut      <= pc;
              fetchValid <= 1'b1;
              pc         <= pc + XLEN'(4);
            end
          end
        end
        HALT: begin
          if (bus.load_valid) begin
            state     <= LOAD;
            wrPtr     <= '0;
            loadReady <= 1'b1;
            halted    <= 1'b0;
          end else if (bus.run) begin
            state  <= RUN;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready  = loadReady;
  assign bus.i_datain    = iData;
  assign bus.pc_out      = pcOut;
  assign bus.fetch_valid = fetchValid;
  assign bus.halted      = halted;
  assign bus.prog_len    = progLen;
endmodule

// File: tb/tb_imem_fetch_server.sv
// Bench for imem_fetch_server: directed scenarios plus randomized runs against a word-level model.
module tb_imem_fetch_server;
  logic clock;
  logic reset;

  imem_fetch_server_if bus();

  imem_fetch_server dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model: program image, loaded length and expected fetch outputs.
  logic [31:0] model [32];
  int          modelLen;
  logic [31:0] expPc;
  logic [31:0] expData;
  logic [31:0] expPcOut;
  logic        expValid;
  logic        expHalted;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.run         = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
  endtask

  task automatic model_clear();
    modelLen  = 0;
    expPc     = '0;
    expData   = '0;
    expPcOut  = '0;
    expValid  = 1'b0;
    expHalted = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic load_words(input logic [31:0] words[$], input bit withLast);
    int accepted;
    accepted = 0;
    foreach (words[i]) begin
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = withLast && (i == words.size() - 1);
      tick();
      if (accepted < 32) begin
        model[accepted] = words[i];
        accepted++;
      end
    end
    idle_inputs();
    modelLen = accepted;
  endtask

  task automatic start_run();
    bus.run = 1'b1;
    tick();
    bus.run   = 1'b0;
    expPc     = '0;
    expHalted = 1'b0;
  endtask

  // One clock of the fetch rules in RUN/HALT, given the control inputs applied before the edge.
  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc);
    if (expHalted) return;
    if (rd) begin
      expPc    = rpc & ~32'h3;
      expData  = '0;
      expValid = 1'b0;
    end else if (!st) begin
`ifdef HALT_ON_END_EN
      if ((expPc >> 2) >= 32'(modelLen)) begin
        expHalted = 1'b1;
        expData   = '0;
        expValid  = 1'b0;
        return;
      end
`endif
      expData  = model[(expPc >> 2) % 32];
      expPcOut = expPc;
      expValid = 1'b1;
      expPc    = expPc + 32'd4;
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted, bus.load_ready, bus.prog_len}
        !== {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0})
      $display("FAIL reset_outputs got %h expected %h",
               {bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted, bus.load_ready, bus.prog_len},
               {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0});
    else passed++;
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_program();
    logic [31:0] q[$];
    q = '{32'h20010005, 32'h20020003, 32'h00221820};
    do_reset();
    load_words(q, 1'b1);
    total++;
    if (bus.prog_len !== 6'd3) $display("FAIL prog_len_3 got %0d expected 3", bus.prog_len);
    else passed++;
    start_run();
    total++;
    if (bus.fetch_valid !== 1'b0) $display("FAIL run_latency got %b expected 0", bus.fetch_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {q[i], 32'(i * 4), 1'b1})
        $display("FAIL program_fetch%0d got %h/%h/%b expected %h/%h/1",
                 i, bus.i_datain, bus.pc_out, bus.fetch_valid, q[i], 32'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_full_load();
    logic [31:0] w [34];
    do_reset();
    for (int i = 0; i < 34; i++) begin
      w[i]           = $urandom;
      bus.load_valid = 1'b1;
      bus.load_data  = w[i];
      total++;
      if (bus.load_ready !== (i < 32))
        $display("FAIL load_ready_word%0d got %b expected %b", i, bus.load_ready, (i < 32));
      else passed++;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = w[i];
    modelLen = 32;
    total++;
    if (bus.prog_len !== 6'd32) $display("FAIL prog_len_32 got %0d expected 32", bus.prog_len);
    else passed++;
    start_run();
    for (int c = 0; c < 34; c++) begin
      tick();
      model_step(1'b0, 1'b0, '0);
      total++;
      if ({bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted}
          !== {expData, expPcOut, expValid, expHalted})
        $display("FAIL full_fetch%0d got %h expected %h", c,
                 {bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted},
                 {expData, expPcOut, expValid, expHalted});
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] q[$];
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    load_words(q, 1'b1);
    start_run();
    tick();
    tick();
    total++;
    if (bus.pc_out !== 32'd4) $display("FAIL stall_setup got %h expected 4", bus.pc_out);
    else passed++;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {q[1], 32'd4, 1'b1})
        $display("FAIL stall_hold%0d got %h/%h expected %h/4", i, bus.i_datain, bus.pc_out, q[1]);
      else passed++;
    end
    bus.stall = 1'b0;
    tick();
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {q[2], 32'd8, 1'b1})
      $display("FAIL stall_resume got %h/%h expected %h/8", bus.i_datain, bus.pc_out, q[2]);
    else passed++;
  endtask

  task automatic test_redirect();
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0007;
    tick();
    total++;
    if ({bus.i_datain, bus.fetch_valid} !== {32'h0, 1'b0})
      $display("FAIL redirect_nop got %h/%b expected 0/0", bus.i_datain, bus.fetch_valid);
    else passed++;
    idle_inputs();
    tick();
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {model[1], 32'd4, 1'b1})
      $display("FAIL redirect_target got %h/%h expected %h/4", bus.i_datain, bus.pc_out, model[1]);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] q[$];
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    load_words(q, 1'b1);
    start_run();
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.pc_out !== 32'h10) $display("FAIL midrun_pc got %h expected 10", bus.pc_out);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted, bus.load_ready, bus.prog_len}
        !== {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0})
      $display("FAIL midrun_async_reset got %h expected %h",
               {bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted, bus.load_ready, bus.prog_len},
               {32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0});
    else passed++;
    tick();
    reset = 1'b0;
    model_clear();
    q = '{32'hCAFE_0001};
    load_words(q, 1'b1);
    start_run();
    tick();
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {32'hCAFE_0001, 32'h0, 1'b1})
      $display("FAIL reload_fetch got %h/%h/%b expected cafe0001/0/1",
               bus.i_datain, bus.pc_out, bus.fetch_valid);
    else passed++;
    tick();
`ifdef HALT_ON_END_EN
    total++;
    if ({bus.halted, bus.fetch_valid, bus.i_datain} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL reload_halt got %b/%b/%h expected 1/0/0", bus.halted, bus.fetch_valid, bus.i_datain);
    else passed++;
`else
    total++;
    if ({bus.pc_out, bus.halted} !== {32'd4, 1'b0})
      $display("FAIL reload_wrap got %h/%b expected 4/0", bus.pc_out, bus.halted);
    else passed++;
`endif
  endtask

  task automatic test_load_priority();
    logic [31:0] q[$];
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    load_words(q, 1'b1);
    bus.run        = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h1234_5678;
    bus.load_last  = 1'b1;
    tick();
    idle_inputs();
    model[0] = 32'h1234_5678;
    modelLen = 1;
    tick();
    total++;
    if ({bus.prog_len, bus.fetch_valid} !== {6'd1, 1'b0})
      $display("FAIL load_beats_run got %0d/%b expected 1/0", bus.prog_len, bus.fetch_valid);
    else passed++;
    start_run();
    tick();
    total++;
    if ({bus.i_datain, bus.pc_out, bus.fetch_valid} !== {32'h1234_5678, 32'h0, 1'b1})
      $display("FAIL priority_fetch got %h/%h expected 12345678/0", bus.i_datain, bus.pc_out);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] rpc;
    bit          st;
    bit          rd;
    int          n;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      q.delete();
      n = int'($urandom_range(1, 32));
      for (int i = 0; i < n; i++) q.push_back($urandom);
      load_words(q, 1'b1);
      total++;
      if (bus.prog_len !== 6'(n)) $display("FAIL rand_prog_len%0d got %0d expected %0d", it, bus.prog_len, n);
      else passed++;
      start_run();
      for (int c = 0; c < 50; c++) begin
        st  = ($urandom % 4) == 0;
        rd  = ($urandom % 10) == 0;
        rpc = (($urandom % 6) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16))
                                    : 32'($urandom_range(0, 4 * n + 12));
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        tick();
        model_step(st, rd, rpc);
        total++;
        if ({bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted}
            !== {expData, expPcOut, expValid, expHalted})
          $display("FAIL rand%0d_cycle%0d got %h expected %h", it, c,
                   {bus.i_datain, bus.pc_out, bus.fetch_valid, bus.halted},
                   {expData, expPcOut, expValid, expHalted});
        else passed++;
      end
      idle_inputs();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_program();
    test_full_load();
    test_stall();
    test_redirect();
    test_reset_mid_run();
    test_load_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
